// File: rtl/atod_axil_ctrl.sv
// atod_axil_ctrl: AXI4-Lite slave capturing A-to-D channel samples with sticky ready/overrun status,
// a capture-cycle counter and a masked, registered interrupt.
module atod_axil_ctrl #(
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_S_AXI_ADDR_WIDTH = 6,
    parameter int NUM_CH = 4,
    parameter int SMP_WIDTH = 12
) (
    input  logic                            ACLK,
    input  logic                            ARESET,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
    input  logic [2:0]                      S_AXI_AWPROT,
    input  logic                            S_AXI_AWVALID,
    output logic                            S_AXI_AWREADY,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
    input  logic                            S_AXI_WVALID,
    output logic                            S_AXI_WREADY,
    output logic [1:0]                      S_AXI_BRESP,
    output logic                            S_AXI_BVALID,
    input  logic                            S_AXI_BREADY,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
    input  logic [2:0]                      S_AXI_ARPROT,
    input  logic                            S_AXI_ARVALID,
    output logic                            S_AXI_ARREADY,
    output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
    output logic [1:0]                      S_AXI_RRESP,
    output logic                            S_AXI_RVALID,
    input  logic                            S_AXI_RREADY,
    input  logic [NUM_CH-1:0]               smp_valid,
    input  logic [NUM_CH*SMP_WIDTH-1:0]     smp_data,
    output logic                            irq
);
    localparam int DW = C_S_AXI_DATA_WIDTH;
    localparam int LSB = $clog2(DW / 8);
    typedef enum logic [1:0] {W_IDLE, W_ACK, W_RESP} w_state_t;
    typedef enum logic [1:0] {R_IDLE, R_ACK, R_DATA} r_state_t;
    w_state_t w_state_q, w_state_d;
    r_state_t r_state_q, r_state_d;
    logic [1:0] bresp_q, bresp_d, rresp_q, rresp_d;
    logic [DW-1:0] rdata_q, rdata_d, cnt_q, cnt_d, wm, rd_val;
    logic enable_q, enable_d, irq_q, irq_d, wr_en, rd_en, clear_cnt, unused_ok;
    logic [NUM_CH-1:0] ready_q, ready_d, ovr_q, ovr_d, mask_q, mask_d, cap, rclr, ready_left;
    logic [2*NUM_CH-1:0] w1c;
    logic [SMP_WIDTH-1:0] data_q [NUM_CH];
    logic [SMP_WIDTH-1:0] data_d [NUM_CH];
    int wi, ri;
    assign wi = 32'(S_AXI_AWADDR[C_S_AXI_ADDR_WIDTH-1:LSB]);
    assign ri = 32'(S_AXI_ARADDR[C_S_AXI_ADDR_WIDTH-1:LSB]);
    assign wr_en = w_state_q == W_ACK;
    assign rd_en = r_state_q == R_ACK;
    assign cap = smp_valid & {NUM_CH{enable_q}};
    assign clear_cnt = wr_en && wi == 0 && S_AXI_WSTRB[0] && S_AXI_WDATA[1];
    assign w1c = (wr_en && wi == 1) ? S_AXI_WDATA[2*NUM_CH-1:0] & wm[2*NUM_CH-1:0] : '0;
    assign unused_ok = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_WDATA, wm, S_AXI_AWADDR, S_AXI_ARADDR};
    always_comb begin
        w_state_d = w_state_q == W_IDLE ? (S_AXI_AWVALID && S_AXI_WVALID ? W_ACK : W_IDLE)
                  : w_state_q == W_ACK ? W_RESP : (S_AXI_BREADY ? W_IDLE : W_RESP);
        r_state_d = r_state_q == R_IDLE ? (S_AXI_ARVALID ? R_ACK : R_IDLE)
                  : r_state_q == R_ACK ? R_DATA : (S_AXI_RREADY ? R_IDLE : R_DATA);
    end
    always_comb begin
        wm = '0;
        for (int b = 0; b < DW / 8; b++) wm[b*8 +: 8] = {8{S_AXI_WSTRB[b]}};
    end
    always_comb begin
        rd_val = '0;
        rclr = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            rclr[c] = rd_en && ri == 4 + c;
            data_d[c] = cap[c] ? smp_data[c*SMP_WIDTH +: SMP_WIDTH] : data_q[c];
            if (ri == 4 + c) rd_val = DW'(data_q[c]);
        end
        if (ri == 0) rd_val = DW'(enable_q);
        if (ri == 1) rd_val = DW'({ovr_q, ready_q});
        if (ri == 2) rd_val = DW'(mask_q);
        if (ri == 3) rd_val = cnt_q;
        // Capture sets win over W1C and read-clear; overrun only judges the post-clear ready bit.
        ready_left = ready_q & ~w1c[NUM_CH-1:0] & ~rclr;
        ready_d = ready_left | cap;
        ovr_d = (ovr_q & ~w1c[2*NUM_CH-1:NUM_CH]) | (cap & ready_left);
        enable_d = (wr_en && wi == 0 && S_AXI_WSTRB[0]) ? S_AXI_WDATA[0] : enable_q;
        mask_d = (wr_en && wi == 2) ? (mask_q & ~wm[NUM_CH-1:0]) | (S_AXI_WDATA[NUM_CH-1:0] & wm[NUM_CH-1:0]) : mask_q;
        cnt_d = clear_cnt ? '0 : cnt_q + DW'(|cap);
        irq_d = |(ready_q & mask_q);
        bresp_d = wr_en ? (wi > 3 + NUM_CH ? 2'b10 : 2'b00) : bresp_q;
        rresp_d = rd_en ? (ri > 3 + NUM_CH ? 2'b10 : 2'b00) : rresp_q;
        rdata_d = rd_en ? rd_val : rdata_q;
    end
    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            w_state_q <= W_IDLE;
            r_state_q <= R_IDLE;
            bresp_q <= '0;
            rresp_q <= '0;
            rdata_q <= '0;
            cnt_q <= '0;
            enable_q <= 1'b0;
            irq_q <= 1'b0;
            ready_q <= '0;
            ovr_q <= '0;
            mask_q <= '0;
            for (int c = 0; c < NUM_CH; c++) data_q[c] <= '0;
        end else begin
            w_state_q <= w_state_d;
            r_state_q <= r_state_d;
            bresp_q <= bresp_d;
            rresp_q <= rresp_d;
            rdata_q <= rdata_d;
            cnt_q <= cnt_d;
            enable_q <= enable_d;
            irq_q <= irq_d;
            ready_q <= ready_d;
            ovr_q <= ovr_d;
            mask_q <= mask_d;
            for (int c = 0; c < NUM_CH; c++) data_q[c] <= data_d[c];
        end
    end
    assign S_AXI_AWREADY = wr_en;
    assign S_AXI_WREADY = wr_en;
    assign S_AXI_BVALID = w_state_q == W_RESP;
    assign S_AXI_BRESP = bresp_q;
    assign S_AXI_ARREADY = rd_en;
    assign S_AXI_RVALID = r_state_q == R_DATA;
    assign S_AXI_RDATA = rdata_q;
    assign S_AXI_RRESP = rresp_q;
    assign irq = irq_q;
endmodule

// File: tb/tb_atod_axil_ctrl.sv
// tb_atod_axil_ctrl: directed checks of the A-to-D AXI4-Lite slave with default parameters
// (32-bit bus, 4 channels, 12-bit samples).
module tb_atod_axil_ctrl;
    localparam int NUM_CH = 4;
    localparam int SW = 12;
    logic clk = 1'b0, rst = 1'b1;
    logic [5:0] awaddr = '0, araddr = '0;
    logic [2:0] awprot = '0, arprot = '0;
    logic awvalid = 1'b0, wvalid = 1'b0, bready = 1'b0, arvalid = 1'b0, rready = 1'b0;
    logic [31:0] wdata = '0;
    logic [3:0] wstrb = '0;
    logic awready, wready, bvalid, arready, rvalid, irq;
    logic [1:0] bresp, rresp;
    logic [31:0] rdata;
    logic [NUM_CH-1:0] smp_valid = '0;
    logic [NUM_CH*SW-1:0] smp_data = '0;
    int checks = 0, errors = 0;
    logic [31:0] rd;
    logic [1:0] rs;

    always #5 clk = ~clk;

    atod_axil_ctrl dut (
        .ACLK(clk), .ARESET(rst),
        .S_AXI_AWADDR(awaddr), .S_AXI_AWPROT(awprot), .S_AXI_AWVALID(awvalid), .S_AXI_AWREADY(awready),
        .S_AXI_WDATA(wdata), .S_AXI_WSTRB(wstrb), .S_AXI_WVALID(wvalid), .S_AXI_WREADY(wready),
        .S_AXI_BRESP(bresp), .S_AXI_BVALID(bvalid), .S_AXI_BREADY(bready),
        .S_AXI_ARADDR(araddr), .S_AXI_ARPROT(arprot), .S_AXI_ARVALID(arvalid), .S_AXI_ARREADY(arready),
        .S_AXI_RDATA(rdata), .S_AXI_RRESP(rresp), .S_AXI_RVALID(rvalid), .S_AXI_RREADY(rready),
        .smp_valid(smp_valid), .smp_data(smp_data), .irq(irq)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic sample(input int ch, input logic [SW-1:0] v);
        smp_valid = '0;
        smp_valid[ch] = 1'b1;
        smp_data[ch*SW +: SW] = v;
        @(posedge clk); #1;
        smp_valid = '0;
    endtask

    // iv/id inject a sample strobe into the cycle where the transfer is accepted
    task automatic axi_write(input logic [5:0] a, input logic [31:0] d, input logic [3:0] s,
                             input logic [NUM_CH-1:0] iv, input logic [NUM_CH*SW-1:0] id,
                             output logic [1:0] resp);
        int n = 0;
        awaddr = a; wdata = d; wstrb = s; awvalid = 1'b1; wvalid = 1'b1; bready = 1'b1;
        do begin @(posedge clk); #1; n++; end while (!awready && n < 20);
        check("awready", 32'(awready), 32'd1);
        check("wready", 32'(wready), 32'd1);
        smp_valid = iv; smp_data = id;
        @(posedge clk); #1;
        smp_valid = '0; awvalid = 1'b0; wvalid = 1'b0; n = 0;
        while (!bvalid && n < 20) begin @(posedge clk); #1; n++; end
        check("bvalid", 32'(bvalid), 32'd1);
        resp = bresp;
        @(posedge clk); #1;
        bready = 1'b0;
    endtask

    task automatic axi_read(input logic [5:0] a, input logic [NUM_CH-1:0] iv, input logic [NUM_CH*SW-1:0] id,
                            output logic [31:0] d, output logic [1:0] resp);
        int n = 0;
        araddr = a; arvalid = 1'b1; rready = 1'b1;
        do begin @(posedge clk); #1; n++; end while (!arready && n < 20);
        check("arready", 32'(arready), 32'd1);
        smp_valid = iv; smp_data = id;
        @(posedge clk); #1;
        smp_valid = '0; arvalid = 1'b0; n = 0;
        while (!rvalid && n < 20) begin @(posedge clk); #1; n++; end
        check("rvalid", 32'(rvalid), 32'd1);
        d = rdata; resp = rresp;
        @(posedge clk); #1;
        rready = 1'b0;
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        check("rst_awready", 32'(awready), 32'd0);
        check("rst_arready", 32'(arready), 32'd0);
        check("rst_bvalid", 32'(bvalid), 32'd0);
        check("rst_rvalid", 32'(rvalid), 32'd0);
        check("rst_irq", 32'(irq), 32'd0);
        check("rst_rdata", rdata, 32'd0);
        for (int i = 0; i < 4; i++) begin
            axi_read(6'(i * 4), '0, '0, rd, rs);
            check("rst_word", rd, 32'd0);
            check("rst_rresp", 32'(rs), 32'd0);
        end
        awvalid = 1'b1; awaddr = 6'h08;
        repeat (3) @(posedge clk);
        #1 check("aw_alone", 32'(awready), 32'd0);
        awvalid = 1'b0;
        axi_write(6'h00, 32'h1, 4'hF, '0, '0, rs);
        check("ctrl_bresp", 32'(rs), 32'd0);
        axi_read(6'h00, '0, '0, rd, rs);
        check("ctrl_rd", rd, 32'h1);
        sample(0, 12'hABC);
        axi_read(6'h04, '0, '0, rd, rs);
        check("status_ch0", rd, 32'h01);
        axi_read(6'h10, '0, '0, rd, rs);
        check("data0", rd, 32'hABC);
        axi_read(6'h0C, '0, '0, rd, rs);
        check("cnt1", rd, 32'd1);
        axi_read(6'h04, '0, '0, rd, rs);
        check("status_rdclr", rd, 32'h00);
        sample(2, 12'h123);
        sample(2, 12'h456);
        axi_read(6'h04, '0, '0, rd, rs);
        check("status_ovr", rd, 32'h44);
        axi_write(6'h04, 32'h40, 4'hF, '0, '0, rs);
        axi_read(6'h04, '0, '0, rd, rs);
        check("status_w1c", rd, 32'h04);
        axi_read(6'h18, '0, '0, rd, rs);
        check("data2", rd, 32'h456);
        axi_read(6'h0C, '0, '0, rd, rs);
        check("cnt3", rd, 32'd3);
        axi_write(6'h08, 32'h2, 4'hF, '0, '0, rs);
        sample(1, 12'h7FF);
        check("irq_n1", 32'(irq), 32'd0);
        @(posedge clk); #1;
        check("irq_n2", 32'(irq), 32'd1);
        axi_read(6'h14, '0, '0, rd, rs);
        check("data1", rd, 32'h7FF);
        check("irq_cleared", 32'(irq), 32'd0);
        axi_read(6'h20, '0, '0, rd, rs);
        check("bad_rdata", rd, 32'd0);
        check("bad_rresp", 32'(rs), 32'd2);
        axi_read(6'h3C, '0, '0, rd, rs);
        check("top_rresp", 32'(rs), 32'd2);
        axi_write(6'h20, 32'hFFFF_FFFF, 4'hF, '0, '0, rs);
        check("bad_bresp", 32'(rs), 32'd2);
        axi_write(6'h0C, 32'h55, 4'hF, '0, '0, rs);
        check("ro_bresp", 32'(rs), 32'd0);
        axi_read(6'h0C, '0, '0, rd, rs);
        check("cnt_ro", rd, 32'd4);
        axi_read(6'h08, '0, '0, rd, rs);
        check("mask_kept", rd, 32'h2);
        axi_write(6'h08, 32'hFFFF_FFFF, 4'b0001, '0, '0, rs);
        axi_read(6'h08, '0, '0, rd, rs);
        check("mask_strb", rd, 32'hF);
        axi_write(6'h08, 32'h0, 4'b0010, '0, '0, rs);
        axi_read(6'h08, '0, '0, rd, rs);
        check("mask_strb_off", rd, 32'hF);
        sample(3, 12'h111);
        axi_read(6'h1C, 4'b1000, {12'h222, 36'h0}, rd, rs);
        check("data3_old", rd, 32'h111);
        axi_read(6'h04, '0, '0, rd, rs);
        check("status_race", rd, 32'h08);
        axi_read(6'h1C, '0, '0, rd, rs);
        check("data3_new", rd, 32'h222);
        axi_read(6'h0C, '0, '0, rd, rs);
        check("cnt6", rd, 32'd6);
        axi_write(6'h00, 32'h3, 4'b0001, 4'b0001, {36'h0, 12'h5A5}, rs);
        axi_read(6'h0C, '0, '0, rd, rs);
        check("cnt_clr_wins", rd, 32'd0);
        axi_read(6'h00, '0, '0, rd, rs);
        check("ctrl_selfclr", rd, 32'h1);
        axi_read(6'h04, '0, '0, rd, rs);
        check("status_clrcap", rd, 32'h01);
        check("irq_mask_f", 32'(irq), 32'd1);
        axi_write(6'h00, 32'h0, 4'b0001, '0, '0, rs);
        sample(1, 12'h333);
        axi_read(6'h14, '0, '0, rd, rs);
        check("disabled_data1", rd, 32'h7FF);
        axi_read(6'h0C, '0, '0, rd, rs);
        check("disabled_cnt", rd, 32'd0);
        awaddr = 6'h00; wdata = 32'h1; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1; bready = 1'b0;
        repeat (3) @(posedge clk);
        #1 check("mid_bvalid", 32'(bvalid), 32'd1);
        #2 rst = 1'b1; awvalid = 1'b0; wvalid = 1'b0;
        #1 check("async_bvalid", 32'(bvalid), 32'd0);
        check("async_irq", 32'(irq), 32'd0);
        @(posedge clk); #1 rst = 1'b0;
        @(posedge clk); #1;
        check("post_rst_bvalid", 32'(bvalid), 32'd0);
        axi_read(6'h04, '0, '0, rd, rs);
        check("post_rst_status", rd, 32'd0);
        axi_read(6'h10, '0, '0, rd, rs);
        check("post_rst_data0", rd, 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
